character_jump_ctrl: RTL and testbench

//  Parametrised player-character motion controller for the SkyHop game.

---
 rtl/character_jump_ctrl_if.sv | 23 ++
 rtl/character_jump_ctrl.sv | 91 +++++++++
 tb/tb_character_jump_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/character_jump_ctrl_if.sv
// character_jump_ctrl_if: control requests and character position/status outputs
interface character_jump_ctrl_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           module_en;
  logic           jump_left;
  logic           jump_right;
  logic [X_W-1:0] character_x;
  logic [Y_W-1:0] character_y;
  logic [3:0]     character_pos;
  logic           busy;
  logic           landed;
  logic           blocked;
  modport master (
    output module_en, jump_left, jump_right,
    input  character_x, character_y, character_pos, busy, landed, blocked
  );
  modport slave (
    input  module_en, jump_left, jump_right,
    output character_x, character_y, character_pos, busy, landed, blocked
  );
endinterface

// File: rtl/character_jump_ctrl.sv
// character_jump_ctrl: column-to-column jump controller animating a triangular arc
module character_jump_ctrl #(
  parameter int N_POS       = 9,
  parameter int START_POS   = 4,
  parameter int X_ORIGIN    = 40,
  parameter int POS_STEP_X  = 80,
  parameter int Y_BASE      = 500,
  parameter int JUMP_HEIGHT = 120,
  parameter int JUMP_STEPS  = 16,
  parameter int TICK_DIV    = 65000,
  parameter int X_W         = 10,
  parameter int Y_W         = 10
) (
  input  logic clk,
  input  logic rst,
  character_jump_ctrl_if.slave bus
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(JUMP_STEPS + 1);
  localparam logic [X_W-1:0] X0   = X_W'(X_ORIGIN + START_POS * POS_STEP_X);
  localparam logic [Y_W-1:0] Y0   = Y_W'(Y_BASE);
  localparam logic [X_W-1:0] DX   = X_W'(POS_STEP_X / JUMP_STEPS);
  localparam logic [Y_W-1:0] DY   = Y_W'(2 * JUMP_HEIGHT / JUMP_STEPS);
  localparam logic [3:0]     P0   = 4'(START_POS);
  localparam logic [3:0]     PMAX = 4'(N_POS - 1);
  typedef enum logic [1:0] {IDLE, RISE, FALL, LAND} state_t;
  state_t         state, state_n;
  logic [TW-1:0]  tick_cnt;
  logic [SW-1:0]  step_cnt;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [3:0]     pos;
  logic           dir, jl_d, jr_d, blocked;
  logic           en, req_l, req_r, moving, wrap, blk, go;
  assign en     = bus.module_en;
  assign req_l  = bus.jump_left & ~jl_d;
  assign req_r  = bus.jump_right & ~jr_d;
  assign moving = state == RISE || state == FALL;
  assign wrap   = moving && tick_cnt == TW'(TICK_DIV - 1);
  assign blk    = state == IDLE && ((req_l && req_r) || (req_l && pos == 4'd0) || (req_r && pos == PMAX));
  assign go     = state == IDLE && (req_l ^ req_r) && !blk;
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else if (en) state <= state_n;
  always_comb
    state_n = state == IDLE ? (go ? RISE : IDLE)
            : state == RISE ? ((wrap && step_cnt == SW'(JUMP_STEPS / 2 - 1)) ? FALL : RISE)
            : state == FALL ? ((wrap && step_cnt == SW'(JUMP_STEPS - 1)) ? LAND : FALL)
            : IDLE;
  always_comb begin
    bus.busy   = state != IDLE;
    bus.landed = state == LAND && en;
  end
  // a frozen controller holds all state but never repeats a pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt <= '0;
      step_cnt <= '0;
      x        <= X0;
      y        <= Y0;
      pos      <= P0;
      dir      <= 1'b0;
      jl_d     <= 1'b0;
      jr_d     <= 1'b0;
      blocked  <= 1'b0;
    end else if (!en) begin
      blocked <= 1'b0;
    end else begin
      jl_d    <= bus.jump_left;
      jr_d    <= bus.jump_right;
      blocked <= blk;
      if (go) begin
        dir      <= req_r;
        tick_cnt <= '0;
        step_cnt <= '0;
      end else if (moving) begin
        tick_cnt <= wrap ? '0 : tick_cnt + TW'(1);
        if (wrap) begin
          x        <= dir ? x + DX : x - DX;
          y        <= state == RISE ? y - DY : y + DY;
          step_cnt <= step_cnt + SW'(1);
        end
      end
      if (state == FALL && state_n == LAND) pos <= dir ? pos + 4'd1 : pos - 4'd1;
    end
  end
  assign bus.character_x   = x;
  assign bus.character_y   = y;
  assign bus.character_pos = pos;
  assign bus.blocked       = blocked;
endmodule

// File: tb/tb_character_jump_ctrl.sv
// tb_character_jump_ctrl: directed checks of jump arc, edge blocking, freeze and reset
module tb_character_jump_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  character_jump_ctrl_if bus ();
  character_jump_ctrl #(.TICK_DIV(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.jump_left = 1'b0;
    bus.jump_right = 1'b0;
    bus.module_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic run_jump(input bit right);
    @(negedge clk);
    if (right) bus.jump_right = 1'b1;
    else bus.jump_left = 1'b1;
    @(negedge clk);
    bus.jump_right = 1'b0;
    bus.jump_left = 1'b0;
    repeat (33) @(negedge clk);
    check("jump_idle", bus.busy, 0);
  endtask
  initial begin
    bus.module_en = 1'b1;
    bus.jump_left = 1'b0;
    bus.jump_right = 1'b0;
    do_reset();
    check("rst_x", bus.character_x, 360);
    check("rst_y", bus.character_y, 500);
    check("rst_pos", bus.character_pos, 4);
    check("rst_busy", bus.busy, 0);
    repeat (10) @(negedge clk);
    check("hold_x", bus.character_x, 360);
    check("hold_y", bus.character_y, 500);
    check("hold_pos", bus.character_pos, 4);
    check("hold_busy", bus.busy, 0);
    // basic right jump, counted in negedges from the request
    bus.jump_right = 1'b1;
    @(negedge clk);
    bus.jump_right = 1'b0;
    check("j_busy1", bus.busy, 1);
    repeat (16) @(negedge clk);
    check("j_apex_y", bus.character_y, 380);
    check("j_apex_x", bus.character_x, 400);
    repeat (15) @(negedge clk);
    check("j_prel_landed", bus.landed, 0);
    @(negedge clk);
    check("j_land_x", bus.character_x, 440);
    check("j_land_y", bus.character_y, 500);
    check("j_land_pos", bus.character_pos, 5);
    check("j_land_pulse", bus.landed, 1);
    check("j_land_busy", bus.busy, 1);
    @(negedge clk);
    check("j_end_busy", bus.busy, 0);
    check("j_end_landed", bus.landed, 0);
    // walk to the left edge, then push against it
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_jump(1'b0);
      check("walk_pos", bus.character_pos, 32'(3 - i));
    end
    check("walk_x", bus.character_x, 40);
    bus.jump_left = 1'b1;
    @(negedge clk);
    bus.jump_left = 1'b0;
    check("edge_blocked", bus.blocked, 1);
    check("edge_busy", bus.busy, 0);
    check("edge_x", bus.character_x, 40);
    check("edge_pos", bus.character_pos, 0);
    @(negedge clk);
    check("edge_blk_pulse", bus.blocked, 0);
    check("edge_busy2", bus.busy, 0);
    // simultaneous requests, then a level held high through a whole jump
    do_reset();
    bus.jump_left = 1'b1;
    bus.jump_right = 1'b1;
    @(negedge clk);
    bus.jump_left = 1'b0;
    bus.jump_right = 1'b0;
    check("both_blocked", bus.blocked, 1);
    check("both_busy", bus.busy, 0);
    @(negedge clk);
    check("both_x", bus.character_x, 360);
    check("both_blk_clr", bus.blocked, 0);
    bus.jump_right = 1'b1;
    repeat (34) @(negedge clk);
    check("held_busy", bus.busy, 0);
    check("held_pos", bus.character_pos, 5);
    repeat (40) @(negedge clk);
    check("held_once_busy", bus.busy, 0);
    check("held_once_pos", bus.character_pos, 5);
    check("held_once_x", bus.character_x, 440);
    bus.jump_right = 1'b0;
    // freeze during RISE with the tick counter mid-count
    do_reset();
    bus.jump_right = 1'b1;
    @(negedge clk);
    bus.jump_right = 1'b0;
    repeat (5) @(negedge clk);
    check("frz_pre_x", bus.character_x, 370);
    check("frz_pre_y", bus.character_y, 470);
    bus.module_en = 1'b0;
    repeat (20) @(negedge clk);
    check("frz_x", bus.character_x, 370);
    check("frz_y", bus.character_y, 470);
    check("frz_busy", bus.busy, 1);
    bus.module_en = 1'b1;
    @(negedge clk);
    check("res_x", bus.character_x, 375);
    check("res_y", bus.character_y, 455);
    repeat (26) @(negedge clk);
    check("res_land_pulse", bus.landed, 1);
    check("res_land_x", bus.character_x, 440);
    check("res_land_y", bus.character_y, 500);
    check("res_land_pos", bus.character_pos, 5);
    @(negedge clk);
    check("res_end_busy", bus.busy, 0);
    // reset mid-jump, then a clean jump
    do_reset();
    bus.jump_right = 1'b1;
    @(negedge clk);
    bus.jump_right = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_x", bus.character_x, 385);
    check("mid_y", bus.character_y, 425);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_x", bus.character_x, 360);
    check("mid_rst_y", bus.character_y, 500);
    check("mid_rst_pos", bus.character_pos, 4);
    check("mid_rst_busy", bus.busy, 0);
    run_jump(1'b1);
    check("after_pos", bus.character_pos, 5);
    check("after_x", bus.character_x, 440);
    check("after_y", bus.character_y, 500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
